// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct codes, ALU control codes and datapath mux selects.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB     = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SIMM     = 2'b10;
    localparam logic [1:0] SRCB_SIMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's aluop request and the R-type
// funct field to an ALU control code, flagging funct values with no mapping.
module mips_alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       funct_illegal
);

    always_comb begin
        alucontrol    = ALU_ADD;
        funct_illegal = 1'b0;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencing controller: Moore main FSM driving datapath
// muxes/enables, stalling on mem_ready, with a retired-instruction counter.
module mips_multicycle_ctrl
    import mips_mc_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pcen,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [2:0]         alucontrol,
    output logic               illegal,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   retired
);

    state_t     cur_state, next_state;
    logic [1:0] aluop;
    logic       funct_illegal;
    logic       pcwrite, branch, retire;
    logic       memwrite_raw, irwrite_raw, regwrite_raw, illegal_raw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur_state <= FETCH;
        else        cur_state <= next_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      retired <= '0;
        else if (retire) retired <= retired + CNT_W'(1);
    end

    // aluop depends on state only so the funct decode feeds the FSM without a loop
    always_comb begin
        aluop = ALUOP_ADD;
        case (cur_state)
            EXECUTE: aluop = ALUOP_FUNCT;
            BRANCH:  aluop = ALUOP_SUB;
            default: aluop = ALUOP_ADD;
        endcase
    end

    mips_alu_decoder u_alu_decoder (
        .aluop         (aluop),
        .funct         (funct),
        .alucontrol    (alucontrol),
        .funct_illegal (funct_illegal)
    );

    always_comb begin
        next_state   = FETCH;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        retire       = 1'b0;
        iord         = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        illegal_raw  = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = SRCB_REGB;
        pcsrc        = PCSRC_ALU;
        case (cur_state)
            FETCH: begin
                alusrcb     = SRCB_FOUR;
                irwrite_raw = mem_ready;
                pcwrite     = mem_ready;
                next_state  = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = SRCB_SIMM_SH2;
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default: begin
                        illegal_raw = 1'b1;
                        next_state  = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_SIMM;
                next_state = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                iord       = 1'b1;
                next_state = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
                retire       = 1'b1;
            end
            MEMWRITE: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
                retire       = mem_ready;
                next_state   = mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTE: begin
                alusrca     = 1'b1;
                illegal_raw = funct_illegal;
                next_state  = funct_illegal ? FETCH : ALUWB;
            end
            ALUWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
                retire       = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                pcsrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
                retire  = 1'b1;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_SIMM;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                regwrite_raw = 1'b1;
                retire       = 1'b1;
            end
            JUMP: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
                retire  = 1'b1;
            end
            default: next_state = FETCH;
        endcase
    end

    // Write-type strobes are masked by reset so nothing commits while it is held
    assign pcen     = reset & (pcwrite | (branch & zero));
    assign irwrite  = reset & irwrite_raw;
    assign regwrite = reset & regwrite_raw;
    assign memwrite = reset & memwrite_raw;
    assign illegal  = reset & illegal_raw;
    assign state    = STATE_W'(cur_state);

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Sequencing controller for the multicycle variant of the MIPS core. It replaces the single-cycle Controller when Datapath shares one memory port for instruction fetch and data access. A Moore main FSM steps each instruction through FETCH/DECODE/execute/writeback states. It drives every datapath mux and enable, stalls on a memory-ready handshake, and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter
STATE_W, 4, width of state register (encodings in package)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completed current access this cycle
pcen  out  1  PC write enable (pcwrite | branch&zero)
iord  out  1  memory address select: 0=PC, 1=ALUOut
memwrite  out  1  data memory write strobe
irwrite  out  1  instruction register load
regdst  out  1  1=rd, 0=rt
memtoreg  out  1  1=memory data, 0=ALUOut
regwrite  out  1  register file write
alusrca  out  1  0=PC, 1=regA
alusrcb  out  2  00=regB, 01=const 4, 10=signimm, 11=signimm<<2
pcsrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target
alucontrol  out  3  ALU operation
illegal  out  1  one-cycle pulse, undecoded opcode/funct
state  out  STATE_W  current state (debug)
retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (reset=0, async): state<=FETCH, retired<=0. While reset=0, pcen, irwrite, regwrite, memwrite and illegal are forced to 0. All other outputs take their FETCH values.
- Outputs are combinational from state, plus mem_ready/zero/funct where noted. No output registers.
- FETCH: iord=0, alusrca=0, alusrcb=01, ALU add, pcsrc=00. irwrite=pcwrite=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, ALU add (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH with illegal=1; retired is not incremented.
- MEMADR: alusrca=1, alusrcb=10, ALU add. Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWRITE: iord=1, memwrite=1. Hold until mem_ready, then FETCH. memwrite stays asserted through the wait.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct:
  - 100000 -> 010 (add)
  - 100010 -> 110 (sub)
  - 100100 -> 000 (and)
  - 100101 -> 001 (or)
  - 101010 -> 111 (slt)
  - Unknown funct: alucontrol=010, illegal=1, next FETCH with no writeback and no retire.
  - Otherwise next ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, ALU sub, pcsrc=01, branch=1, so pcen=zero -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, ALU add -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JUMP: pcsrc=10, pcwrite=1 -> FETCH.
- Any unused state encoding -> FETCH next cycle, all enables 0.
- Latency with mem_ready held 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles.
- retired increments by 1, wrapping modulo 2^CNT_W, on each cycle whose next state is FETCH from MEMWB, MEMWRITE (with mem_ready=1), ALUWB, BRANCH, ADDIWB or JUMP.
- Enables not listed for a state are 0. Mux selects not listed are 0.
- Reset asserted mid-instruction aborts it immediately; no partial writes after reset assertion.

Decomposition:
- Package mips_mc_pkg holds:
  - state encodings: FETCH=0, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  - opcode and funct constants
  - ALU control codes and alusrcb/pcsrc select constants
- Sub-module mips_alu_decoder: combinational. Takes aluop[1:0] (00 add, 01 sub, 10 funct) and funct; returns alucontrol and funct_illegal.

Test Plan:
- Reset low mid-EXECUTE, then release -> state=FETCH, retired=0, pcen=irwrite=regwrite=memwrite=0 while reset low.
- lw (opcode 100011), mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; regwrite=1, memtoreg=1 in cycle 5; retired 0->1.
- sw with mem_ready low 3 cycles in MEMWRITE -> memwrite held 4 cycles; FETCH after mem_ready=1; retired +1 once.
- beq zero=1 then zero=0 -> pcen=1 / pcen=0 in BRANCH, pcsrc=01; 3 cycles each.
- R-type funct 101010 -> alucontrol=111 in EXECUTE, regdst=1 regwrite=1 in ALUWB; funct 111111 -> illegal pulse, no regwrite, retired unchanged.
- opcode 111111 -> DECODE->FETCH, illegal=1 one cycle. CNT_W=4 after 16 retirements -> retired=0.
